fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: owns the program counter and drives the word-addressed instruction memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles hazard-unit stall, decode flush and EX-stage branch/jump redirect.
- Halts on an illegal fetch address (misaligned or outside the instruction memory).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_WORDS, 64, number of 32-bit words in instruction memory; legal word index 0..IMEM_WORDS-1.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard unit: hold PC and IF/ID.
flush_d  input  1  clear IF/ID to bubble.
pc_src_e  input  1  taken branch/jump resolved in EX.
pc_target_e  input  32  redirect target from EX.
imem_addr  output  32  byte address to instruction memory (= pc_f).
imem_inst  input  32  instruction word returned combinationally for imem_addr.
instr_d  output  32  IF/ID instruction.
pc_d  output  32  IF/ID PC.
pc_plus4_d  output  32  IF/ID PC+4.
valid_d  output  1  IF/ID holds a real instruction.
fetch_fault  output  1  sticky illegal-fetch flag.
fault_pc  output  32  PC that caused the fault.
fetch_count  output  32  count of valid instructions delivered to IF/ID.

Behaviour:
- Reset (clk edge with reset=1) overrides everything, including mid-stall and FAULT:
  - pc_f=RESET_PC, instr_d=32'h0000_0013 (NOP), pc_d=0, pc_plus4_d=0, valid_d=0.
  - fetch_fault=0, fault_pc=0, fetch_count=0, state=RUN.
- imem_addr = pc_f, purely combinational, in every state. Memory index is imem_addr[31:2], so fetch latency is 0 cycles and the instruction appears in IF/ID 1 cycle after its PC is presented.
- pc_plus4 = pc_f + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- illegal = (pc_f[1:0] != 0) or (pc_f[31:2] >= IMEM_WORDS).
- States: RUN, FAULT.
- RUN, PC update priority:
  1. pc_src_e=1: pc_f <= pc_target_e. Redirect wins over stall.
  2. stall=1: hold pc_f.
  3. illegal: hold pc_f.
  4. Otherwise: pc_f <= pc_plus4.
- RUN, IF/ID update priority:
  1. flush_d=1: bubble (instr_d=NOP, pc_d=0, pc_plus4_d=0, valid_d=0).
  2. stall=1: hold all IF/ID fields.
  3. pc_src_e=1 without flush_d: bubble. The current fetch is wrong-path.
  4. illegal: bubble; fault_pc<=pc_f; fetch_fault<=1; state<=FAULT.
  5. Otherwise capture: instr_d=imem_inst, pc_d=pc_f, pc_plus4_d=pc_plus4, valid_d=1; fetch_count<=fetch_count+1 (wraps to 0 after 32'hFFFF_FFFF).
- No fault is taken on a wrong-path or stalled fetch, i.e. when pc_src_e, stall or flush_d is 1. The check applies only when the fetch would actually be captured.
- A misaligned or out-of-range pc_target_e is accepted into pc_f; it faults on the next cycle that would capture.
- FAULT:
  - pc_f frozen; IF/ID forced to bubble every cycle; fetch_count frozen.
  - stall, flush_d and pc_src_e are ignored.
  - fetch_fault and fault_pc held.
  - Exit only via reset.
- fetch_count increments only on step 5, never on bubble, hold or fault.

Test Plan:
1. Reset then 4 free-running cycles with imem words 0..3 = A0..A3 -> imem_addr 0,4,8,12. instr_d A0..A3 one cycle after each address, pc_d 0..12, valid_d=1, fetch_count=4.
2. stall=1 for 2 cycles at pc_f=8 -> imem_addr stays 8, IF/ID holds A1 with pc_d=4, fetch_count unchanged. After release, A2 is captured with pc_d=8.
3. pc_src_e=1, flush_d=1, pc_target_e=0x20 while pc_f=0x10 -> next cycle pc_f=0x20 and valid_d=0, no fault. The following cycle instr_d=word 8 with pc_d=0x20.
4. Redirect to 0x22 -> the cycle after, fetch_fault=1, fault_pc=0x22, valid_d=0. Subsequent pc_src_e, stall and flush_d are ignored and pc_f stays 0x22. reset returns pc_f=0 and fetch_fault=0.
5. Sequential fetch reaching pc_f=0x100 with IMEM_WORDS=64 -> fault, fault_pc=0x100. Fetch at 0xFC succeeds normally.
6. stall=1 and pc_src_e=1 in the same cycle, flush_d=0 -> pc_f takes the target. IF/ID holds because stall outranks the redirect bubble. reset asserted during a stall -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register; halts in FAULT on an illegal fetch until reset.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_id_q;
    logic [31:0] pc_plus4_id_q;
    logic        valid_q;
    logic [31:0] fault_pc_q;
    logic [31:0] fetch_count_q;

    logic [31:0] pc_plus4;
    logic        illegal;

    assign pc_plus4 = pc_q + 32'd4;
    assign illegal  = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            instr_q       <= NOP;
            pc_id_q       <= 32'd0;
            pc_plus4_id_q <= 32'd0;
            valid_q       <= 1'b0;
            fault_pc_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            case (state_q)
                RUN: begin
                    // Redirect outranks stall for the PC; an illegal PC simply waits to fault.
                    if (pc_src_e) begin
                        pc_q <= pc_target_e;
                    end else if (!stall && !illegal) begin
                        pc_q <= pc_plus4;
                    end

                    if (flush_d) begin
                        instr_q       <= NOP;
                        pc_id_q       <= 32'd0;
                        pc_plus4_id_q <= 32'd0;
                        valid_q       <= 1'b0;
                    end else if (stall) begin
                        instr_q       <= instr_q;
                    end else if (pc_src_e) begin
                        instr_q       <= NOP;
                        pc_id_q       <= 32'd0;
                        pc_plus4_id_q <= 32'd0;
                        valid_q       <= 1'b0;
                    end else if (illegal) begin
                        // Only a fetch that would really be captured may fault.
                        instr_q       <= NOP;
                        pc_id_q       <= 32'd0;
                        pc_plus4_id_q <= 32'd0;
                        valid_q       <= 1'b0;
                        fault_pc_q    <= pc_q;
                        state_q       <= FAULT;
                    end else begin
                        instr_q       <= imem_inst;
                        pc_id_q       <= pc_q;
                        pc_plus4_id_q <= pc_plus4;
                        valid_q       <= 1'b1;
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end
                end
                FAULT: begin
                    instr_q       <= NOP;
                    pc_id_q       <= 32'd0;
                    pc_plus4_id_q <= 32'd0;
                    valid_q       <= 1'b0;
                end
                default: state_q <= FAULT;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign instr_d     = instr_q;
    assign pc_d        = pc_id_q;
    assign pc_plus4_d  = pc_plus4_id_q;
    assign valid_d     = valid_q;
    assign fetch_fault = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the fetch scenarios, then random
// stall/flush/redirect traffic checked against a cycle-level reference model.
module tb_fetch_stage;

    localparam int          WORDS = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [WORDS];

    int total;
    int bad;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_fpc;
    logic [31:0] m_cnt;

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(WORDS)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .fetch_fault (fetch_fault),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory; out-of-range reads return a recognisable junk word.
    assign imem_inst = (imem_addr[31:8] == 24'd0) ? mem[imem_addr[7:2]] : 32'hBAD0_0BAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr",   imem_addr,          m_pc);
        chk("instr_d",     instr_d,            m_instr);
        chk("pc_d",        pc_d,               m_pcd);
        chk("pc_plus4_d",  pc_plus4_d,         m_pc4);
        chk("valid_d",     {31'd0, valid_d},   {31'd0, m_valid});
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("fault_pc",    fault_pc,           m_fpc);
        chk("fetch_count", fetch_count,        m_cnt);
    endtask

    task automatic bubble_model();
        m_instr = NOP;
        m_pcd   = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
    endtask

    // Advances the reference by one clock from the architectural rules.
    task automatic model_clock(input logic rst, input logic st, input logic fl,
                               input logic src, input logic [31:0] tgt);
        logic        bad_pc;
        logic [31:0] next_pc;
        if (rst) begin
            m_pc = 32'd0; bubble_model();
            m_fault = 1'b0; m_fpc = 32'd0; m_cnt = 32'd0;
        end else if (m_fault) begin
            bubble_model();
        end else begin
            bad_pc  = (m_pc % 4 != 0) || (m_pc / 4 >= WORDS);
            next_pc = src ? tgt : ((st || bad_pc) ? m_pc : m_pc + 32'd4);
            if (fl || (!st && src)) begin
                bubble_model();
            end else if (st) begin
                // hold
            end else if (bad_pc) begin
                bubble_model();
                m_fault = 1'b1;
                m_fpc   = m_pc;
            end else begin
                m_instr = mem[m_pc / 4];
                m_pcd   = m_pc;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
            m_pc = next_pc;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic fl,
                        input logic src, input logic [31:0] tgt);
        reset       = rst;
        stall       = st;
        flush_d     = fl;
        pc_src_e    = src;
        pc_target_e = tgt;
        model_clock(rst, st, fl, src, tgt);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        reset = 1'b1; stall = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = 32'd0;
        m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0;
        m_valid = 1'b0; m_fault = 1'b0; m_fpc = 32'd0; m_cnt = 32'd0;

        // Reset state
        step(1, 0, 0, 0, 0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_addr", imem_addr, 32'd0);

        // Free-running fetch of words 0..3
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("t1_count", fetch_count, 32'd4);
        chk("t1_instr", instr_d, mem[3]);
        chk("t1_pcd", pc_d, 32'd12);

        // Stall at pc_f=8
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t2_addr", imem_addr, 32'd8);
        chk("t2_instr", instr_d, mem[1]);
        chk("t2_count", fetch_count, 32'd2);
        step(0, 0, 0, 0, 0);
        chk("t2_rel_instr", instr_d, mem[2]);
        chk("t2_rel_pcd", pc_d, 32'd8);

        // Redirect with flush at pc_f=0x10
        step(0, 0, 0, 0, 0);
        chk("t3_pre_addr", imem_addr, 32'h10);
        step(0, 0, 1, 1, 32'h20);
        chk("t3_addr", imem_addr, 32'h20);
        chk("t3_valid", {31'd0, valid_d}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("t3_instr", instr_d, mem[8]);
        chk("t3_pcd", pc_d, 32'h20);

        // Misaligned redirect faults on the next capture; FAULT ignores controls
        step(0, 0, 0, 1, 32'h22);
        chk("t4_nofault", {31'd0, fetch_fault}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("t4_fault", {31'd0, fetch_fault}, 32'd1);
        chk("t4_fpc", fault_pc, 32'h22);
        step(0, 0, 0, 1, 32'h40);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 32'h8);
        chk("t4_frozen", imem_addr, 32'h22);
        step(1, 0, 0, 0, 0);
        chk("t4_rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("t4_rst_addr", imem_addr, 32'd0);

        // Sequential run to the end of memory
        for (int i = 0; i < WORDS; i++) step(0, 0, 0, 0, 0);
        chk("t5_last_pcd", pc_d, 32'hFC);
        chk("t5_last_valid", {31'd0, valid_d}, 32'd1);
        chk("t5_count", fetch_count, 32'd64);
        step(0, 0, 0, 0, 0);
        chk("t5_fault", {31'd0, fetch_fault}, 32'd1);
        chk("t5_fpc", fault_pc, 32'h100);

        // Stall together with redirect, then reset during a stall
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 32'h40);
        chk("t6_addr", imem_addr, 32'h40);
        chk("t6_hold_pcd", pc_d, 32'd4);
        chk("t6_hold_valid", {31'd0, valid_d}, 32'd1);
        step(1, 1, 0, 0, 0);
        chk("t6_rst_count", fetch_count, 32'd0);
        chk("t6_rst_valid", {31'd0, valid_d}, 32'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(0, 9) == 0)
                tgt = ($urandom_range(0, 1) == 0) ? ($urandom_range(0, 127) * 4 + 32'd256)
                                                  : ($urandom_range(0, 255) | 32'd1);
            else
                tgt = $urandom_range(0, WORDS - 1) * 4;
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
